// File: rtl/snoop_bus_pkg.sv
// Shared types and constants for the snooping MESI bus responder:
// request-type codes, responder FSM encoding and default geometry.
package snoop_bus_pkg;

  localparam int DEF_N_PROC = 3;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] REQ_RD_MISS = 2'd0;
  localparam logic [1:0] REQ_WR_MISS = 2'd1;
  localparam logic [1:0] REQ_INV     = 2'd2;
  localparam logic [1:0] REQ_RSV     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNOOP   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WB      = 3'd3,
    ST_MEM     = 3'd4,
    ST_RESP    = 3'd5
  } bus_state_e;

  // Width of a processor index; never zero so a single-processor bus still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter.sv
// Bus arbiter: one-hot winner plus its index. With SNOOP_RR_ARB_EN defined the
// search starts at ptr and next_ptr is winner+1 mod N_PROC; otherwise lowest index wins.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter  int N_PROC = DEF_N_PROC,
  localparam int IDX_W  = idx_w(N_PROC)
) (
  input  logic [N_PROC-1:0] req,
`ifdef SNOOP_RR_ARB_EN
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  next_ptr,
`endif
  output logic [N_PROC-1:0] winner,
  output logic [IDX_W-1:0]  winner_idx,
  output logic              any_req
);

`ifdef SNOOP_RR_ARB_EN
  int   cand;
  logic found;

  always_comb begin
    cand       = 0;
    found      = 1'b0;
    winner_idx = '0;
    any_req    = |req;
    for (int i = 0; i < N_PROC; i++) begin
      cand = (int'(ptr) + i) % N_PROC;
      if (!found && req[cand]) begin
        found      = 1'b1;
        winner_idx = IDX_W'(cand);
      end
    end
    next_ptr = (int'(winner_idx) == N_PROC - 1) ? '0 : winner_idx + 1'b1;
    winner   = any_req ? (N_PROC'(1) << winner_idx) : '0;
  end
`else
  always_comb begin
    winner_idx = '0;
    any_req    = |req;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner_idx = IDX_W'(i);
      end
    end
    winner = any_req ? (N_PROC'(1) << winner_idx) : '0;
  end
`endif

endmodule

// File: rtl/snoop_bus_responder.sv
// Memory-side responder of the snooping MESI bus: arbitrates, broadcasts, absorbs
// M-state writebacks, owns shared memory. Arbitration policy selected by SNOOP_RR_ARB_EN.
module snoop_bus_responder
  import snoop_bus_pkg::*;
#(
  parameter int N_PROC = DEF_N_PROC,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PROC-1:0]        req,
  input  logic [2*N_PROC-1:0]      req_type,
  input  logic [ADDR_W*N_PROC-1:0] req_addr,
  input  logic [DATA_W*N_PROC-1:0] req_data,
  output logic [N_PROC-1:0]        grant,
  output logic                     snoop_valid,
  output logic [1:0]               snoop_type,
  output logic [ADDR_W-1:0]        snoop_addr,
  input  logic [N_PROC-1:0]        snoop_share,
  input  logic [N_PROC-1:0]        snoop_abort,
  input  logic [DATA_W*N_PROC-1:0] snoop_wb_data,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_share
);

  localparam int IDX_W = idx_w(N_PROC);
  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0]        type_arr  [N_PROC];
  logic [ADDR_W-1:0] addr_arr  [N_PROC];
  logic [DATA_W-1:0] wdata_arr [N_PROC];
  logic [DATA_W-1:0] wb_arr    [N_PROC];

  for (genvar gi = 0; gi < N_PROC; gi++) begin : g_unpack
    assign type_arr[gi]  = req_type[2*gi +: 2];
    assign addr_arr[gi]  = req_addr[ADDR_W*gi +: ADDR_W];
    assign wdata_arr[gi] = req_data[DATA_W*gi +: DATA_W];
    assign wb_arr[gi]    = snoop_wb_data[DATA_W*gi +: DATA_W];
  end

  bus_state_e        state_q, state_d;
  logic [N_PROC-1:0] grant_q, grant_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              share_q, share_d;
  logic [IDX_W-1:0]  aborter_q, aborter_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [N_PROC-1:0] arb_winner;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
`ifdef SNOOP_RR_ARB_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  arb_next_ptr;
`endif

  snoop_bus_arbiter #(
    .N_PROC(N_PROC)
  ) u_arbiter (
    .req        (req),
`ifdef SNOOP_RR_ARB_EN
    .ptr        (ptr_q),
    .next_ptr   (arb_next_ptr),
`endif
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .any_req    (arb_any)
  );

  // The requester never snoops its own request, so its response bits are ignored.
  logic [N_PROC-1:0] share_masked, abort_masked;
  logic [IDX_W-1:0]  abort_idx;

  assign share_masked = snoop_share & ~grant_q;
  assign abort_masked = snoop_abort & ~grant_q;

  always_comb begin
    abort_idx = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (abort_masked[i]) begin
        abort_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    share_d   = share_q;
    aborter_d = aborter_q;
`ifdef SNOOP_RR_ARB_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_winner;
          type_d  = type_arr[arb_idx];
          addr_d  = addr_arr[arb_idx];
          wdata_d = wdata_arr[arb_idx];
`ifdef SNOOP_RR_ARB_EN
          ptr_d   = arb_next_ptr;
`endif
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: state_d = ST_COLLECT;
      ST_COLLECT: begin
        share_d = |share_masked;
        if (|abort_masked) begin
          aborter_d = abort_idx;
          state_d   = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:   state_d = ST_MEM;
      ST_MEM:  state_d = ST_RESP;
      ST_RESP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      type_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      share_q   <= 1'b0;
      aborter_q <= '0;
`ifdef SNOOP_RR_ARB_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      share_q   <= share_d;
      aborter_q <= aborter_d;
`ifdef SNOOP_RR_ARB_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // WB and MEM are distinct cycles, so a read miss after an abort sees the writeback.
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (!reset) begin
      if (state_q == ST_WB) begin
        mem_we    = 1'b1;
        mem_wdata = wb_arr[aborter_q];
      end else if (state_q == ST_MEM && type_q == REQ_WR_MISS) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
    if (state_q == ST_MEM && type_q == REQ_RD_MISS) begin
      data_q <= mem[addr_q];
    end
  end

  assign grant       = grant_q;
  assign snoop_valid = (state_q == ST_SNOOP);
  assign snoop_type  = type_q;
  assign snoop_addr  = addr_q;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = (resp_valid && type_q == REQ_RD_MISS) ? data_q : '0;
  assign resp_share  = resp_valid && (type_q == REQ_RD_MISS) && share_q;

endmodule

// File: tb/tb_snoop_bus_responder.sv
// Self-checking bench for snoop_bus_responder: per-transaction expected output
// trace from a transaction-level model, compared every negedge, plus literal checks.
module tb_snoop_bus_responder;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_type;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    grant;
  logic            snoop_valid;
  logic [1:0]      snoop_type;
  logic [AW-1:0]   snoop_addr;
  logic [N-1:0]    snoop_share;
  logic [N-1:0]    snoop_abort;
  logic [DW*N-1:0] snoop_wb_data;
  logic            resp_valid;
  logic [DW-1:0]   resp_data;
  logic            resp_share;

  snoop_bus_responder #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock         (clk),
    .reset         (rst),
    .req           (req),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .grant         (grant),
    .snoop_valid   (snoop_valid),
    .snoop_type    (snoop_type),
    .snoop_addr    (snoop_addr),
    .snoop_share   (snoop_share),
    .snoop_abort   (snoop_abort),
    .snoop_wb_data (snoop_wb_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_share    (resp_share)
  );

  typedef struct {
    logic [N-1:0]  grant;
    logic          sv;
    logic [1:0]    st;
    logic [AW-1:0] sa;
    logic          rv;
    logic [DW-1:0] rd;
    logic          rs;
  } rec_t;

  rec_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_txn = 0;
  bit            chk_en = 1'b0;
  logic [DW-1:0] shadow [32];
`ifdef SNOOP_RR_ARB_EN
  int            m_ptr = 0;
`endif
  logic [N-1:0]  last_grant;
  logic [DW-1:0] last_data;
  logic          last_share;
  logic [1:0]    last_stype;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [N-1:0] g, input logic sv, input logic [1:0] st,
                              input logic [AW-1:0] sa, input logic rv, input logic [DW-1:0] rd,
                              input logic rs);
    rec_t r;
    r.grant = g; r.sv = sv; r.st = st; r.sa = sa; r.rv = rv; r.rd = rd; r.rs = rs;
    return r;
  endfunction

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  // Every negedge: pop the expected output set, or expect a quiet bus when nothing is queued.
  always @(negedge clk) begin
    rec_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk('0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0);
      check("grant", 32'(grant), 32'(e.grant));
      check("snoop_valid", 32'(snoop_valid), 32'(e.sv));
      if (e.sv) begin
        check("snoop_type", 32'(snoop_type), 32'(e.st));
        check("snoop_addr", 32'(snoop_addr), 32'(e.sa));
      end
      check("resp_valid", 32'(resp_valid), 32'(e.rv));
      check("resp_data", 32'(resp_data), 32'(e.rd));
      check("resp_share", 32'(resp_share), 32'(e.rs));
      if (snoop_valid === 1'b1) last_stype = snoop_type;
      if (resp_valid === 1'b1) begin
        last_grant = grant;
        last_data  = resp_data;
        last_share = resp_share;
      end
    end
  end

  // All requesters in rq present the same type/addr/data; the model picks the winner.
  task automatic run_txn(input logic [N-1:0] rq, input logic [1:0] ty, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [N-1:0] sh, input logic [N-1:0] ab,
                         input logic [DW*N-1:0] wb, input bit hold, input int drop_at,
                         input int rst_at, output int lat);
    int            w;
    int            abi;
    logic [N-1:0]  g;
    logic [N-1:0]  oth;
    logic [N-1:0]  abm;
    logic          she;
    logic [DW-1:0] val;
    req           = rq;
    req_type      = {N{ty}};
    req_addr      = {N{ad}};
    req_data      = {N{wd}};
    snoop_share   = sh;
    snoop_abort   = ab;
    snoop_wb_data = wb;
    w = -1;
`ifdef SNOOP_RR_ARB_EN
    for (int i = 0; i < N; i++) begin
      if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
    end
    m_ptr = (w + 1) % N;
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (rq[i]) w = i;
    end
`endif
    g = '0;
    g[w] = 1'b1;
    oth = ~g;
    she = |(sh & oth);
    abm = ab & oth;
    abi = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (abm[i]) abi = i;
    end
    if (rst_at == 0) begin
      if (abi >= 0) shadow[ad] = wb[abi*DW +: DW];
      if (ty == 2'd1) shadow[ad] = wd;
    end
    val = (ty == 2'd0) ? shadow[ad] : '0;
    exp_q.push_back(mk(g, 1'b1, ty, ad, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(g, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0));
    if (abi >= 0) exp_q.push_back(mk(g, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(g, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0));
    exp_q.push_back(mk(g, 1'b0, 2'd0, '0, 1'b1, val, (ty == 2'd0) ? she : 1'b0));
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (c == drop_at) req = '0;
      if (c == rst_at) begin
        rst = 1'b1;
        req = '0;
        exp_q.delete();
`ifdef SNOOP_RR_ARB_EN
        m_ptr = 0;
`endif
        cycle();
        check("rst_snoop_type", 32'(snoop_type), 32'd0);
        check("rst_snoop_addr", 32'(snoop_addr), 32'd0);
        rst = 1'b0;
        lat = -1;
        break;
      end
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_timeout: no resp_valid within 12 cycles, required one");
      exp_q.delete();
    end
    if (!hold) req = '0;
    n_txn++;
    $display("txn %0d: req=%b type=%0d addr=%0d grant=%b resp_data=%h resp_share=%b lat=%0d",
             n_txn, rq, ty, ad, last_grant, last_data, last_share, lat);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [N-1:0] exp_arb [4];
`ifdef SNOOP_RR_ARB_EN
    exp_arb[0] = 3'b001; exp_arb[1] = 3'b010; exp_arb[2] = 3'b100; exp_arb[3] = 3'b001;
`else
    exp_arb[0] = 3'b001; exp_arb[1] = 3'b001; exp_arb[2] = 3'b001; exp_arb[3] = 3'b001;
`endif
    rst = 1'b1; req = '0; req_type = '0; req_addr = '0; req_data = '0;
    snoop_share = '0; snoop_abort = '0; snoop_wb_data = '0;
    repeat (3) cycle();
    chk_en = 1'b1;
    cycle();
    check("reset_snoop_type", 32'(snoop_type), 32'd0);
    check("reset_snoop_addr", 32'(snoop_addr), 32'd0);
    rst = 1'b0;
    cycle();

    // mem[5] = 0x3C via proc1 write miss
    run_txn(3'b010, 2'd1, 5'd5, 8'h3C, 3'b000, 3'b000, '0, 1'b0, 0, 0, lat);
    check("wr5_lat", 32'(lat), 32'd4);
    check("wr5_data", 32'(last_data), 32'h0);

    run_txn(3'b001, 2'd0, 5'd5, 8'h00, 3'b000, 3'b000, '0, 1'b0, 0, 0, lat);
    check("rd5_lat", 32'(lat), 32'd4);
    check("rd5_data", 32'(last_data), 32'h3C);
    check("rd5_share", 32'(last_share), 32'd0);
    check("rd5_grant", 32'(last_grant), 32'b001);

    run_txn(3'b010, 2'd0, 5'd5, 8'h00, 3'b011, 3'b000, '0, 1'b0, 0, 0, lat);
    check("shared_data", 32'(last_data), 32'h3C);
    check("shared_share", 32'(last_share), 32'd1);

    run_txn(3'b010, 2'd0, 5'd5, 8'h00, 3'b010, 3'b000, '0, 1'b0, 0, 0, lat);
    check("own_share_ignored", 32'(last_share), 32'd0);

    run_txn(3'b001, 2'd1, 5'd9, 8'h11, 3'b000, 3'b000, '0, 1'b0, 0, 0, lat);

    run_txn(3'b001, 2'd0, 5'd9, 8'h00, 3'b100, 3'b100, {8'hA5, 8'h00, 8'h00}, 1'b0, 0, 0, lat);
    check("wb_lat", 32'(lat), 32'd5);
    check("wb_data", 32'(last_data), 32'hA5);

    // req dropped right after the snoop; transaction must still complete
    run_txn(3'b010, 2'd0, 5'd9, 8'h00, 3'b000, 3'b000, '0, 1'b0, 1, 0, lat);
    check("wb_mem_after", 32'(last_data), 32'hA5);
    check("drop_lat", 32'(lat), 32'd4);

    run_txn(3'b100, 2'd0, 5'd9, 8'h00, 3'b000, 3'b100, {8'hFF, 8'h00, 8'h00}, 1'b0, 0, 0, lat);
    check("own_abort_lat", 32'(lat), 32'd4);
    check("own_abort_data", 32'(last_data), 32'hA5);

    run_txn(3'b001, 2'd0, 5'd7, 8'h00, 3'b000, 3'b110, {8'h42, 8'h21, 8'h00}, 1'b0, 0, 0, lat);
    check("low_aborter_data", 32'(last_data), 32'h21);

    run_txn(3'b010, 2'd1, 5'd3, 8'h7E, 3'b000, 3'b000, '0, 1'b0, 0, 0, lat);
    check("wr3_data", 32'(last_data), 32'h0);

    run_txn(3'b010, 2'd2, 5'd3, 8'h00, 3'b001, 3'b000, '0, 1'b0, 0, 0, lat);
    check("inv_lat", 32'(lat), 32'd4);
    check("inv_snoop_type", 32'(last_stype), 32'd2);
    check("inv_share", 32'(last_share), 32'd0);

    run_txn(3'b010, 2'd0, 5'd3, 8'h00, 3'b000, 3'b000, '0, 1'b0, 0, 0, lat);
    check("rd3_after_inv", 32'(last_data), 32'h7E);

    // reset lands while the write miss is in MEM
    run_txn(3'b001, 2'd1, 5'd3, 8'h55, 3'b000, 3'b000, '0, 1'b0, 0, 3, lat);

    for (int i = 0; i < 4; i++) begin
      run_txn(3'b111, 2'd0, 5'd5, 8'h00, 3'b000, 3'b000, '0, (i < 3), 0, 0, lat);
      check("arb_grant", 32'(last_grant), 32'(exp_arb[i]));
    end

    run_txn(3'b100, 2'd0, 5'd3, 8'h00, 3'b000, 3'b000, '0, 1'b0, 0, 0, lat);
    check("rd3_after_reset", 32'(last_data), 32'h7E);

    repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
